// File: rtl/cnn_pkg.sv
// Shared constants, memory bank codes and pooling FSM states for the CNN layer stages.
package cnn_pkg;

    localparam int IMG_W  = 64;
    localparam int DW     = 20;
    localparam int AW     = 12;
    localparam int NUM_CH = 2;

    localparam int OUT_W = IMG_W / 2;
    localparam int PW    = $clog2(OUT_W);
    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [2:0] CSEL_NONE  = 3'b000;
    localparam logic [2:0] CSEL_L0_K0 = 3'b001;
    localparam logic [2:0] CSEL_L0_K1 = 3'b010;
    localparam logic [2:0] CSEL_L1_K0 = 3'b011;
    localparam logic [2:0] CSEL_L1_K1 = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_LAST,
        ST_WR,
        ST_NXCH,
        ST_DONE
    } pool_state_e;

    function automatic logic [2:0] l0_bank(input logic [CW-1:0] ch);
        return (ch == '0) ? CSEL_L0_K0 : CSEL_L0_K1;
    endfunction

    function automatic logic [2:0] l1_bank(input logic [CW-1:0] ch);
        return (ch == '0) ? CSEL_L1_K0 : CSEL_L1_K1;
    endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Window/pixel/channel counters for 2x2 stride-2 pooling; forms the L0 read and L1 write addresses.
module pool_addr_gen
    import cnn_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          win_step_i,
    input  logic          pix_step_i,
    input  logic          ch_step_i,
    output logic [1:0]    win_o,
    output logic [CW-1:0] ch_o,
    output logic [AW-1:0] caddr_rd_o,
    output logic [AW-1:0] caddr_wr_o,
    output logic          last_win_o,
    output logic          last_ch_o
);

    logic [PW-1:0] pr_q, pr_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [1:0]    win_q, win_d;
    logic [PW:0]   rd_row;
    logic [PW:0]   rd_col;

    // NOTE: every variable gets its default before any branch, so no path leaves it unassigned (no latch).
    always_comb begin
        pr_d  = pr_q;
        pc_d  = pc_q;
        ch_d  = ch_q;
        win_d = win_q;
        if (clr_i) begin
            pr_d  = '0;
            pc_d  = '0;
            ch_d  = '0;
            win_d = '0;
        end else begin
            if (win_step_i) begin
                win_d = win_q + 2'd1;
            end
            if (pix_step_i) begin
                if (pc_q == PW'(OUT_W - 1)) begin
                    pc_d = '0;
                    pr_d = pr_q + 1'b1;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            if (ch_step_i) begin
                ch_d = ch_q + 1'b1;
                pr_d = '0;
                pc_d = '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pr_q  <= '0;
            pc_q  <= '0;
            ch_q  <= '0;
            win_q <= '0;
        end else begin
            pr_q  <= pr_d;
            pc_q  <= pc_d;
            ch_q  <= ch_d;
            win_q <= win_d;
        end
    end

    // Window index bit 1 picks the bottom row, bit 0 the right column.
    assign rd_row = {pr_q, win_q[1]};
    assign rd_col = {pc_q, win_q[0]};

    assign caddr_rd_o = AW'(rd_row) * AW'(IMG_W) + AW'(rd_col);
    assign caddr_wr_o = AW'(pr_q) * AW'(OUT_W) + AW'(pc_q);

    assign win_o      = win_q;
    assign ch_o       = ch_q;
    assign last_win_o = (pr_q == PW'(OUT_W - 1)) && (pc_q == PW'(OUT_W - 1));
    assign last_ch_o  = (ch_q == CW'(NUM_CH - 1));

endmodule

// File: rtl/maxpool_l1.sv
// Layer-1 2x2/stride-2 max pooling: reads each L0 map, keeps the signed maximum per window, writes L1.
module maxpool_l1
    import cnn_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);

    pool_state_e   state_q, state_d;
    logic [DW-1:0] mx_q;
    logic          rd_vld_q;
    logic          rd_first_q;

    logic          ag_clr, ag_win_step, ag_pix_step, ag_ch_step;
    logic [1:0]    win;
    logic [CW-1:0] ch;
    logic [AW-1:0] ag_rd_addr, ag_wr_addr;
    logic          last_win, last_ch;

    pool_addr_gen u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (ag_clr),
        .win_step_i (ag_win_step),
        .pix_step_i (ag_pix_step),
        .ch_step_i  (ag_ch_step),
        .win_o      (win),
        .ch_o       (ch),
        .caddr_rd_o (ag_rd_addr),
        .caddr_wr_o (ag_wr_addr),
        .last_win_o (last_win),
        .last_ch_o  (last_ch)
    );

    always_comb begin
        state_d     = state_q;
        ag_clr      = 1'b0;
        ag_win_step = 1'b0;
        ag_pix_step = 1'b0;
        ag_ch_step  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        crd         = 1'b0;
        cwr         = 1'b0;
        csel        = CSEL_NONE;
        unique case (state_q)
            ST_IDLE: begin
                ag_clr = 1'b1;
                if (start) state_d = ST_RD;
            end
            ST_RD: begin
                busy        = 1'b1;
                crd         = 1'b1;
                csel        = l0_bank(ch);
                ag_win_step = 1'b1;
                if (win == 2'd3) state_d = ST_LAST;
            end
            ST_LAST: begin
                busy    = 1'b1;
                state_d = ST_WR;
            end
            ST_WR: begin
                busy        = 1'b1;
                cwr         = 1'b1;
                csel        = l1_bank(ch);
                ag_pix_step = 1'b1;
                if (!last_win)    state_d = ST_RD;
                else if (last_ch) state_d = ST_DONE;
                else              state_d = ST_NXCH;
            end
            ST_NXCH: begin
                busy       = 1'b1;
                ag_ch_step = 1'b1;
                state_d    = ST_RD;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address/data buses are held at zero outside their strobes.
    assign caddr_rd = crd ? ag_rd_addr : '0;
    assign caddr_wr = cwr ? ag_wr_addr : '0;
    assign cdata_wr = cwr ? mx_q : '0;

    // Read data lands one cycle after crd; the TL sample loads mx, later ones win only if strictly larger.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mx_q       <= '0;
            rd_vld_q   <= 1'b0;
            rd_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_vld_q   <= crd;
            rd_first_q <= crd && (win == 2'd0);
            if (rd_vld_q && (rd_first_q || ($signed(cdata_rd) > $signed(mx_q)))) begin
                mx_q <= cdata_rd;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_l1.sv
// Directed and randomized bench for maxpool_l1 against a max-of-four reference model.
module tb_maxpool_l1;
    import cnn_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy, done, crd, cwr;
    logic [AW-1:0] caddr_rd, caddr_wr;
    logic [DW-1:0] cdata_rd, cdata_wr;
    logic [2:0]    csel;

    always #5 clk = ~clk;

    maxpool_l1 dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
        .csel     (csel)
    );

    typedef struct {
        int            cyc;
        logic [2:0]    csel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic [DW-1:0] l0     [NUM_CH][IMG_W*IMG_W];
    logic [DW-1:0] l1_dut [NUM_CH][OUT_W*OUT_W];
    wr_t wr_log[$];
    wr_t ref_log[$];

    int n_checks = 0;
    int n_errors = 0;

    int first_rd, first_rd_ch1, first_wr, last_wr;
    int done_cnt, done_cyc, busy_c0, busy_cend;
    int n_wr [NUM_CH];
    int n_wr_bad, n_overlap, n_abort_bad;
    int rd_addr [1:4];

    // L0 memory model: data appears the cycle after the read strobe, junk otherwise.
    always @(posedge clk) begin
        if (crd && csel == CSEL_L0_K0)      cdata_rd <= l0[0][caddr_rd];
        else if (crd && csel == CSEL_L0_K1) cdata_rd <= l0[1][caddr_rd];
        else                                cdata_rd <= DW'($urandom);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_pool(input int ch, input int pr, input int pc);
        int best, v;
        best = int'($signed(l0[ch][(2*pr)*IMG_W + 2*pc]));
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                v = int'($signed(l0[ch][(2*pr+dr)*IMG_W + 2*pc+dc]));
                if (v > best) best = v;
            end
        end
        return DW'(best);
    endfunction

    task automatic sample(input int k, input int abort_at);
        wr_t e;
        assert (!(crd && cwr)) else n_overlap++;
        if (k >= 1 && k <= 4) rd_addr[k] = crd ? int'(caddr_rd) : -1;
        if (crd && first_rd < 0) first_rd = k;
        if (crd && csel == CSEL_L0_K1 && first_rd_ch1 < 0) first_rd_ch1 = k;
        if (cwr) begin
            if (first_wr < 0) first_wr = k;
            last_wr = k;
            e.cyc = k; e.csel = csel; e.addr = caddr_wr; e.data = cdata_wr;
            wr_log.push_back(e);
            if (csel == CSEL_L1_K0 && caddr_wr < AW'(OUT_W*OUT_W)) begin
                n_wr[0]++; l1_dut[0][caddr_wr] = cdata_wr;
            end else if (csel == CSEL_L1_K1 && caddr_wr < AW'(OUT_W*OUT_W)) begin
                n_wr[1]++; l1_dut[1][caddr_wr] = cdata_wr;
            end else begin
                n_wr_bad++;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = k;
        end
        if (k == 0)     busy_c0   = int'(busy);
        if (k == 12290) busy_cend = int'(busy);
        if (abort_at >= 0 && k > abort_at && (busy || crd || cwr || csel != 3'b000)) n_abort_bad++;
    endtask

    // Start pulse is cycle 0; optional second start and one-cycle reset at given cycles.
    task automatic run_pool(input int extra_start, input int abort_at, input int max_cyc);
        first_rd = -1; first_rd_ch1 = -1; first_wr = -1; last_wr = -1;
        done_cnt = 0; done_cyc = -1; busy_c0 = -1; busy_cend = -1;
        n_wr_bad = 0; n_overlap = 0; n_abort_bad = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            n_wr[c] = 0;
            for (int a = 0; a < OUT_W*OUT_W; a++) l1_dut[c][a] = 'x;
        end
        for (int i = 1; i <= 4; i++) rd_addr[i] = -1;
        wr_log.delete();
        @(posedge clk); #1;
        start = 1'b1;
        for (int k = 0; k <= max_cyc; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                start = (k == extra_start);
                reset = (k == abort_at);
            end
            @(negedge clk);
            sample(k, abort_at);
            if (done_cnt > 0 && k >= done_cyc + 3) break;
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic check_maps(input string tag);
        int mism;
        for (int c = 0; c < NUM_CH; c++) begin
            mism = 0;
            for (int pr = 0; pr < OUT_W; pr++)
                for (int pc = 0; pc < OUT_W; pc++)
                    if (l1_dut[c][pr*OUT_W + pc] !== ref_pool(c, pr, pc)) mism++;
            check($sformatf("%s_map_ch%0d", tag, c), mism, 0);
        end
        check({tag, "_writes_ch0"}, n_wr[0], OUT_W*OUT_W);
        check({tag, "_writes_ch1"}, n_wr[1], OUT_W*OUT_W);
        check({tag, "_bad_bank"}, n_wr_bad, 0);
        check({tag, "_overlap"}, n_overlap, 0);
        check({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    task automatic compare_log(input string tag);
        int mism;
        mism = (wr_log.size() == ref_log.size()) ? 0 : 1;
        for (int i = 0; i < wr_log.size() && i < ref_log.size(); i++)
            if (wr_log[i].cyc != ref_log[i].cyc || wr_log[i].csel !== ref_log[i].csel ||
                wr_log[i].addr !== ref_log[i].addr || wr_log[i].data !== ref_log[i].data) mism++;
        check({tag, "_wr_seq"}, mism, 0);
    endtask

    task automatic load_ramp();
        for (int a = 0; a < IMG_W*IMG_W; a++) begin
            l0[0][a] = DW'(a);
            l0[1][a] = DW'(-a);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_crd", crd, 1'b0);
        check("rst_cwr", cwr, 1'b0);
        check("rst_csel", csel, 3'b000);
        @(posedge clk); #1;
        reset = 1'b0;

        // Ramp on ch0, negated ramp on ch1, with full timing checks.
        load_ramp();
        run_pool(-1, -1, 12400);
        check_maps("ramp");
        check("ramp_l1k0_0", l1_dut[0][0], 20'd65);
        check("ramp_l1k0_1", l1_dut[0][1], 20'd67);
        check("ramp_l1k0_1023", l1_dut[0][1023], 20'd4095);
        check("neg_l1k1_0", l1_dut[1][0], 20'h00000);
        check("neg_l1k1_34", l1_dut[1][34], 20'hFFF7C);
        check("t_busy_c0", busy_c0, 0);
        check("t_first_rd", first_rd, 1);
        check("t_rd_addr1", rd_addr[1], 0);
        check("t_rd_addr2", rd_addr[2], 1);
        check("t_rd_addr3", rd_addr[3], 64);
        check("t_rd_addr4", rd_addr[4], 65);
        check("t_first_wr", first_wr, 6);
        check("t_ch0_last_wr", (wr_log.size() > 1023) ? wr_log[1023].cyc : -1, 6144);
        check("t_ch1_first_rd", first_rd_ch1, 6146);
        check("t_last_wr", last_wr, 12289);
        check("t_done_cyc", done_cyc, 12290);
        check("t_busy_end", busy_cend, 0);
        ref_log = wr_log;

        // Second start while busy must change nothing.
        run_pool(500, -1, 12400);
        compare_log("busy_start");
        check("busy_start_done_cyc", done_cyc, 12290);
        check("busy_start_done_cnt", done_cnt, 1);

        // Plateau: all samples tie.
        for (int c = 0; c < NUM_CH; c++)
            for (int a = 0; a < IMG_W*IMG_W; a++) l0[c][a] = 20'h00010;
        run_pool(-1, -1, 12400);
        check_maps("plateau");
        check("plateau_l1k1_517", l1_dut[1][517], 20'h00010);

        // Random full-range signed data.
        for (int c = 0; c < NUM_CH; c++)
            for (int a = 0; a < IMG_W*IMG_W; a++) l0[c][a] = DW'($urandom);
        run_pool(-1, -1, 12400);
        check_maps("random");

        // Random small values around zero, so ties and sign flips are frequent.
        for (int c = 0; c < NUM_CH; c++)
            for (int a = 0; a < IMG_W*IMG_W; a++) l0[c][a] = DW'(int'($urandom_range(0, 6)) - 3);
        run_pool(-1, -1, 12400);
        check_maps("small");

        // Reset mid-run aborts; a fresh start then reproduces the ramp run.
        load_ramp();
        run_pool(-1, 3000, 3300);
        check("abort_outputs_idle", n_abort_bad, 0);
        check("abort_writes", n_wr[0], 500);
        check("abort_no_done", done_cnt, 0);
        check("abort_overlap", n_overlap, 0);
        run_pool(-1, -1, 12400);
        check_maps("rerun");
        compare_log("rerun");
        check("rerun_done_cyc", done_cyc, 12290);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
